ccx_emem_responder: RTL and testbench

- Target end of the core's emem memory interface: accepts emem requests and returns emem_gnt, emem_err and emem_rdata.
- Backs one address window with a single-port synchronous SRAM: 64-bit words, byte strobes, 1-cycle read latency.
- Adds programmable wait states, and returns an error for out-of-window accesses and for under-privileged writes.
- Sits in the SoC/FPGA top between ccx_top's emem port and an on-chip RAM macro or BRAM.

---
 rtl/ccx_emem_pkg.sv | 21 ++
 rtl/ccx_emem_addr_check.sv | 39 +++
 rtl/ccx_emem_responder.sv | 139 +++++++++++++
 tb/tb_ccx_emem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccx_emem_pkg.sv
// Shared emem field widths, responder FSM states and privilege encodings.
package ccx_emem_pkg;

  localparam int ADDR_W = 39;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int PRV_W  = 2;

  localparam logic [PRV_W-1:0] PRV_U = 2'd0;
  localparam logic [PRV_W-1:0] PRV_S = 2'd1;
  localparam logic [PRV_W-1:0] PRV_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP,
    ST_ERR
  } emem_state_e;

endpackage

// File: rtl/ccx_emem_addr_check.sv
// Window / depth / privilege check for an emem target; yields error flag and SRAM word index.
module ccx_emem_addr_check
  import ccx_emem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE          = 39'h0010_0000,
  parameter logic [ADDR_W-1:0] SIZE          = 39'h000F_FFFF,
  parameter int                MEM_AW        = 17,
  parameter logic [PRV_W-1:0]  PRV_MIN_WRITE = 2'b00
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [PRV_W-1:0]  prv,
  input  logic              rtype,
  output logic              err,
  output logic [MEM_AW-1:0] word_idx
);

  // One extra bit so neither the offset nor the limit wraps.
  logic [ADDR_W:0] offset;
  logic [ADDR_W:0] limit;
  logic [ADDR_W:0] off_word;
  logic            below;
  logic            above;
  logic            too_deep;
  logic            prv_low;

  assign offset   = {1'b0, addr} - {1'b0, BASE};
  assign limit    = {1'b0, BASE} + {1'b0, SIZE};
  assign off_word = offset >> 3;

  assign below    = addr < BASE;
  assign above    = {1'b0, addr} > limit;
  assign too_deep = off_word >= ((ADDR_W+1)'(1) << MEM_AW);
  assign prv_low  = wen && (prv < PRV_MIN_WRITE);

  assign err      = below || above || too_deep || prv_low || (wen && rtype);
  assign word_idx = off_word[MEM_AW-1:0];

endmodule

// File: rtl/ccx_emem_responder.sv
// emem target backed by a single-port synchronous SRAM, with optional wait states.
//
// state     | meaning
// IDLE      | waiting for emem_req; request checked and captured here
// WAIT      | burning WAIT_CYCLES before the SRAM access
// ACCESS    | SRAM enabled for exactly this cycle
// RESP      | gnt with SRAM read data (or 0 for writes)
// ERR       | gnt with err, no SRAM access
module ccx_emem_responder
  import ccx_emem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE          = 39'h0010_0000,
  parameter logic [ADDR_W-1:0] SIZE          = 39'h000F_FFFF,
  parameter int                MEM_AW        = 17,
  parameter int                WAIT_CYCLES   = 0,
  parameter logic [PRV_W-1:0]  PRV_MIN_WRITE = 2'b00
) (
  input  logic              f_clk,
  input  logic              g_resetn,
  input  logic              emem_req,
  input  logic              emem_rtype,
  input  logic [ADDR_W-1:0] emem_addr,
  input  logic              emem_wen,
  input  logic [STRB_W-1:0] emem_strb,
  input  logic [DATA_W-1:0] emem_wdata,
  input  logic [PRV_W-1:0]  emem_prv,
  output logic              emem_gnt,
  output logic              emem_err,
  output logic [DATA_W-1:0] emem_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [STRB_W-1:0] sram_strb,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  emem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] word_q, word_d;
  logic              wen_q, wen_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              chk_err;
  logic [MEM_AW-1:0] chk_word;

  ccx_emem_addr_check #(
    .BASE         (BASE),
    .SIZE         (SIZE),
    .MEM_AW       (MEM_AW),
    .PRV_MIN_WRITE(PRV_MIN_WRITE)
  ) u_addr_check (
    .addr    (emem_addr),
    .wen     (emem_wen),
    .prv     (emem_prv),
    .rtype   (emem_rtype),
    .err     (chk_err),
    .word_idx(chk_word)
  );

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wen_q   <= wen_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wen_d      = wen_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    emem_gnt   = 1'b0;
    emem_err   = 1'b0;
    emem_rdata = '0;
    sram_cen   = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_strb  = '0;
    sram_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (emem_req) begin
          word_d  = chk_word;
          wen_d   = emem_wen;
          strb_d  = emem_strb;
          wdata_d = emem_wdata;
          if (chk_err) begin
            state_d = ST_ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        sram_cen   = 1'b1;
        sram_wen   = wen_q;
        sram_addr  = word_q;
        sram_strb  = wen_q ? strb_q : '0;
        sram_wdata = wdata_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        emem_gnt   = 1'b1;
        emem_rdata = wen_q ? '0 : sram_rdata;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        emem_gnt = 1'b1;
        emem_err = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccx_emem_responder.sv
// Two responder instances (no-wait/strict-write and 5-wait/shallow SRAM) against a transaction-level model.
module tb_ccx_emem_responder;

  localparam logic [38:0] BASE = 39'h0010_0000;
  localparam logic [38:0] SIZE = 39'h000F_FFFF;

  logic             clk;
  logic [1:0]       rstn, req, wen, rtype;
  logic [1:0][38:0] addr;
  logic [1:0][7:0]  strb;
  logic [1:0][63:0] wdata;
  logic [1:0][1:0]  prv;
  logic [1:0]       gnt, err, cen, swen;
  logic [1:0][63:0] rdata, swdata, srd;
  logic [1:0][7:0]  sstrb;
  logic [16:0]      saddr_a;
  logic [9:0]       saddr_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [63:0] smem [longint];
  logic [63:0] refm [longint];

  ccx_emem_responder #(.BASE(BASE), .SIZE(SIZE), .MEM_AW(17), .WAIT_CYCLES(0), .PRV_MIN_WRITE(2'd3)) dut_a (
    .f_clk(clk), .g_resetn(rstn[0]), .emem_req(req[0]), .emem_rtype(rtype[0]), .emem_addr(addr[0]),
    .emem_wen(wen[0]), .emem_strb(strb[0]), .emem_wdata(wdata[0]), .emem_prv(prv[0]),
    .emem_gnt(gnt[0]), .emem_err(err[0]), .emem_rdata(rdata[0]), .sram_cen(cen[0]), .sram_wen(swen[0]),
    .sram_addr(saddr_a), .sram_strb(sstrb[0]), .sram_wdata(swdata[0]), .sram_rdata(srd[0]));

  ccx_emem_responder #(.BASE(BASE), .SIZE(SIZE), .MEM_AW(10), .WAIT_CYCLES(5), .PRV_MIN_WRITE(2'd0)) dut_b (
    .f_clk(clk), .g_resetn(rstn[1]), .emem_req(req[1]), .emem_rtype(rtype[1]), .emem_addr(addr[1]),
    .emem_wen(wen[1]), .emem_strb(strb[1]), .emem_wdata(wdata[1]), .emem_prv(prv[1]),
    .emem_gnt(gnt[1]), .emem_err(err[1]), .emem_rdata(rdata[1]), .sram_cen(cen[1]), .sram_wen(swen[1]),
    .sram_addr(saddr_b), .sram_strb(sstrb[1]), .sram_wdata(swdata[1]), .sram_rdata(srd[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waitc(int i);  return (i == 0) ? 0 : 5;  endfunction
  function automatic int prvmin(int i); return (i == 0) ? 3 : 0;  endfunction
  function automatic int memaw(int i);  return (i == 0) ? 17 : 10; endfunction
  function automatic longint sa(int i); return (i == 0) ? longint'(saddr_a) : longint'(saddr_b); endfunction
  function automatic longint key(int i, longint w); return (longint'(i) << 32) | w; endfunction

  function automatic logic [63:0] smem_rd(longint k);
    if (smem.exists(k)) return smem[k];
    return 64'd0;
  endfunction

  function automatic logic [63:0] ref_rd(longint k);
    if (refm.exists(k)) return refm[k];
    return 64'd0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc %0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic preload(input int i, input longint w, input logic [63:0] v);
    smem[key(i, w)] = v;
    refm[key(i, w)] = v;
  endtask

  // SRAM models: 1-cycle read latency, byte-strobed writes.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cen[i]) begin
        automatic longint k = key(i, sa(i));
        automatic logic [63:0] cur = smem_rd(k);
        if (swen[i]) begin
          for (int b = 0; b < 8; b++)
            if (sstrb[i][b]) cur[8*b +: 8] = swdata[i][8*b +: 8];
          smem[k] = cur;
        end else begin
          srd[i] <= cur;
        end
      end
    end
  end

  // Transaction-level model: a captured request produces one cen at T+1+W and gnt at T+1 (error) or T+2+W.
  bit          act [2];
  bit          m_err [2], m_wen [2];
  int          t_gnt [2], t_cen [2], ncen [2];
  longint      m_word [2];
  logic [7:0]  m_strb [2];
  logic [63:0] m_wd [2];

  function automatic bit model_err(int i, logic [63:0] a, bit w, int p, bit rt);
    logic [63:0] b   = 64'(BASE);
    logic [63:0] lim = 64'(BASE) + 64'(SIZE);
    if (a < b || a > lim) return 1'b1;
    if (((a - b) >> 3) >= (64'd1 << memaw(i))) return 1'b1;
    return (w && p < prvmin(i)) || (w && rt);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        act[i] = 1'b0;
        chk("rst_gnt", i, 64'(gnt[i]), 64'd0);
        chk("rst_err", i, 64'(err[i]), 64'd0);
        chk("rst_rdata", i, rdata[i], 64'd0);
        chk("rst_cen", i, 64'(cen[i]), 64'd0);
      end else begin
        automatic bit eg, ec;
        if (!act[i] && req[i]) begin
          act[i]    = 1'b1;
          m_err[i]  = model_err(i, 64'(addr[i]), wen[i], int'(prv[i]), rtype[i]);
          m_wen[i]  = wen[i];
          m_strb[i] = strb[i];
          m_wd[i]   = wdata[i];
          m_word[i] = (longint'(addr[i]) - longint'(BASE)) >>> 3;
          t_cen[i]  = cyc + 1 + waitc(i);
          t_gnt[i]  = m_err[i] ? cyc + 1 : cyc + 2 + waitc(i);
        end
        eg = act[i] && (cyc == t_gnt[i]);
        ec = act[i] && !m_err[i] && (cyc == t_cen[i]);
        if (cen[i]) ncen[i]++;
        chk("gnt", i, 64'(gnt[i]), 64'(eg));
        if (eg) chk("err", i, 64'(err[i]), 64'(m_err[i]));
        chk("rdata", i, rdata[i], (eg && !m_err[i] && !m_wen[i]) ? ref_rd(key(i, m_word[i])) : 64'd0);
        chk("cen", i, 64'(cen[i]), 64'(ec));
        if (ec) begin
          automatic logic [63:0] cur = ref_rd(key(i, m_word[i]));
          chk("sram_wen", i, 64'(swen[i]), 64'(m_wen[i]));
          chk("sram_addr", i, 64'(sa(i)), 64'(m_word[i]));
          chk("sram_strb", i, 64'(sstrb[i]), m_wen[i] ? 64'(m_strb[i]) : 64'd0);
          chk("sram_wdata", i, swdata[i], m_wd[i]);
          if (m_wen[i]) begin
            for (int b = 0; b < 8; b++)
              if (m_strb[i][b]) cur[8*b +: 8] = m_wd[i][8*b +: 8];
            refm[key(i, m_word[i])] = cur;
          end
        end
        if (eg) act[i] = 1'b0;
      end
    end
  end

  task automatic xact(input int i, input logic [38:0] a, input logic w, input logic [7:0] s,
                      input logic [63:0] wd, input logic [1:0] p, input logic rt,
                      output int lat, output logic e, output logic [63:0] rd);
    int t0;
    bit got;
    @(posedge clk); #1;
    addr[i] = a; wen[i] = w; strb[i] = s; wdata[i] = wd; prv[i] = p; rtype[i] = rt;
    req[i] = 1'b1;
    t0 = cyc; got = 1'b0; lat = -1; e = 1'bx; rd = 'x;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (gnt[i]) begin
        got = 1'b1; lat = cyc - t0; e = err[i]; rd = rdata[i];
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout inst%0d: got no gnt want gnt within 40 cycles", i);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  int lat, t0, ng, c0;
  int gc [3];
  logic e;
  logic [63:0] rd;

  initial begin
    rstn = '0; req = '0; wen = '0; rtype = '0; addr = '0; strb = '0; wdata = '0; prv = '0; srd = '0;
    preload(0, 1, 64'hDEAD_BEEF_0123_4567);
    preload(0, 2, 64'hAAAA_BBBB_CCCC_DDDD);
    preload(0, 3, 64'h5555_6666_7777_8888);
    preload(1, 0, 64'h0000_0000_0000_A000);
    preload(1, 1, 64'h0000_0000_0000_B001);
    preload(1, 2, 64'h0000_0000_0000_C002);
    preload(1, 1023, 64'h0123_0000_0000_03FF);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_literal_gnt", 0, 64'(gnt), 64'd0);
    chk("rst_literal_cen", 0, 64'(cen), 64'd0);
    @(negedge clk); rstn = 2'b11;
    repeat (2) @(posedge clk);

    // Instance A: no wait states, writes need prv >= 3.
    xact(0, BASE + 39'd8, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("rd1_lat", 0, 64'(lat), 64'd2); chk("rd1_err", 0, 64'(e), 64'd0);
    chk("rd1_data", 0, rd, 64'hDEAD_BEEF_0123_4567);

    xact(0, BASE + 39'd16, 1, 8'h0F, 64'h1111_2222_3333_4444, 2'd3, 0, lat, e, rd);
    chk("wr2_lat", 0, 64'(lat), 64'd2); chk("wr2_err", 0, 64'(e), 64'd0); chk("wr2_rdata", 0, rd, 64'd0);
    chk("wr2_mem", 0, smem_rd(key(0, 2)), 64'hAAAA_BBBB_3333_4444);
    xact(0, BASE + 39'd16, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("rb2_err", 0, 64'(e), 64'd0); chk("rb2_data", 0, rd, 64'hAAAA_BBBB_3333_4444);

    xact(0, BASE + SIZE + 39'd1, 0, 8'h00, 64'd0, 2'd3, 0, lat, e, rd);
    chk("oob_hi_lat", 0, 64'(lat), 64'd1); chk("oob_hi_err", 0, 64'(e), 64'd1); chk("oob_hi_rd", 0, rd, 64'd0);
    xact(0, BASE - 39'd8, 0, 8'h00, 64'd0, 2'd3, 0, lat, e, rd);
    chk("oob_lo_lat", 0, 64'(lat), 64'd1); chk("oob_lo_err", 0, 64'(e), 64'd1); chk("oob_lo_rd", 0, rd, 64'd0);

    xact(0, BASE + 39'd24, 1, 8'hFF, 64'hFEDC_BA98_7654_3210, 2'd0, 0, lat, e, rd);
    chk("prv_lo_lat", 0, 64'(lat), 64'd1); chk("prv_lo_err", 0, 64'(e), 64'd1);
    chk("prv_lo_mem", 0, smem_rd(key(0, 3)), 64'h5555_6666_7777_8888);
    xact(0, BASE + 39'd24, 1, 8'hFF, 64'hFEDC_BA98_7654_3210, 2'd3, 0, lat, e, rd);
    chk("prv_m_err", 0, 64'(e), 64'd0);
    chk("prv_m_mem", 0, smem_rd(key(0, 3)), 64'hFEDC_BA98_7654_3210);

    xact(0, BASE + 39'd24, 1, 8'hFF, 64'd0, 2'd3, 1, lat, e, rd);
    chk("fetch_wr_err", 0, 64'(e), 64'd1);
    chk("fetch_wr_mem", 0, smem_rd(key(0, 3)), 64'hFEDC_BA98_7654_3210);
    xact(0, BASE + 39'd8, 1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, lat, e, rd);
    chk("strb0_lat", 0, 64'(lat), 64'd2); chk("strb0_err", 0, 64'(e), 64'd0);
    chk("strb0_mem", 0, smem_rd(key(0, 1)), 64'hDEAD_BEEF_0123_4567);
    xact(0, BASE + 39'd13, 0, 8'h00, 64'd0, 2'd0, 1, lat, e, rd);
    chk("unal_fetch_err", 0, 64'(e), 64'd0); chk("unal_fetch_rd", 0, rd, 64'hDEAD_BEEF_0123_4567);
    xact(0, BASE + SIZE, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("last_byte_lat", 0, 64'(lat), 64'd2); chk("last_byte_err", 0, 64'(e), 64'd0);

    // Instance B: 5 wait states, 1024-word SRAM; three reads with req held high.
    c0 = ncen[1];
    @(posedge clk); #1;
    addr[1] = BASE; wen[1] = 0; strb[1] = '0; wdata[1] = '0; prv[1] = 2'd0; rtype[1] = 0;
    req[1] = 1'b1; t0 = cyc; ng = 0;
    for (int k = 0; k < 100 && ng < 3; k++) begin
      @(negedge clk);
      if (gnt[1]) begin
        gc[ng] = cyc; ng++;
        @(posedge clk); #1;
        if (ng < 3) addr[1] = BASE + 39'(8 * ng);
        else req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    chk("b2b_count", 1, 64'(ng), 64'd3);
    if (ng == 3) begin
      chk("b2b_lat", 1, 64'(gc[0] - t0), 64'd7);
      chk("b2b_gap1", 1, 64'(gc[1] - gc[0]), 64'd8);
      chk("b2b_gap2", 1, 64'(gc[2] - gc[1]), 64'd8);
    end
    repeat (2) @(posedge clk);
    chk("b2b_cen", 1, 64'(ncen[1] - c0), 64'd3);

    xact(1, BASE + 39'd8192, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("deep_lat", 1, 64'(lat), 64'd1); chk("deep_err", 1, 64'(e), 64'd1);
    xact(1, BASE + 39'd8184, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("top_word_lat", 1, 64'(lat), 64'd7); chk("top_word_err", 1, 64'(e), 64'd0);
    chk("top_word_rd", 1, rd, 64'h0123_0000_0000_03FF);

    // Reset while in WAIT: everything drops at once and no gnt follows.
    @(posedge clk); #1;
    addr[1] = BASE + 39'd8; wen[1] = 0; req[1] = 1'b1;
    repeat (3) @(posedge clk);
    #2; rstn[1] = 1'b0;
    #1;
    chk("arst_gnt", 1, 64'(gnt[1]), 64'd0);
    chk("arst_cen", 1, 64'(cen[1]), 64'd0);
    chk("arst_rdata", 1, rdata[1], 64'd0);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn[1] = 1'b1;
    repeat (2) @(posedge clk);
    xact(1, BASE + 39'd16, 0, 8'h00, 64'd0, 2'd0, 0, lat, e, rd);
    chk("post_rst_lat", 1, 64'(lat), 64'd7); chk("post_rst_err", 1, 64'(e), 64'd0);
    chk("post_rst_rd", 1, rd, 64'h0000_0000_0000_C002);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
